// File: rtl/mips_ctrl_alu_if.sv
// Bundle between the MIPS sequencing/decode/ALU core and its datapath and memory master.
// The master side is the controller; the slave side is the datapath that feeds it.
interface mips_ctrl_alu_if;
    logic        waitrequest;
    logic        pc_zero;
    logic [31:0] instr;
    logic [1:0]  addr_lsb;
    logic [31:0] alu_a;
    logic [31:0] alu_b;

    logic        active;
    logic [2:0]  state;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic        inwrite;
    logic        pcwrite;
    logic        regwrite;
    logic        pctoadd;
    logic        alusrc;
    logic        signed_imm;
    logic        regdst;
    logic        link;
    logic        memtoreg;
    logic        loadimmed;
    logic        hitoreg;
    logic        lotoreg;
    logic        regtojump;
    logic        branch;
    logic        jump;
    logic        bytewrite;
    logic        halfwrite;
    logic [2:0]  extend_op;
    logic        div_mult_en;
    logic        div_mult_signed;
    logic [1:0]  div_mult_op;
    logic [31:0] result;
    logic        zero;

    modport master (
        input  waitrequest, pc_zero, instr, addr_lsb, alu_a, alu_b,
        output active, state, read, write, byteenable, inwrite, pcwrite, regwrite,
               pctoadd, alusrc, signed_imm, regdst, link, memtoreg, loadimmed,
               hitoreg, lotoreg, regtojump, branch, jump, bytewrite, halfwrite,
               extend_op, div_mult_en, div_mult_signed, div_mult_op, result, zero
    );

    modport slave (
        output waitrequest, pc_zero, instr, addr_lsb, alu_a, alu_b,
        input  active, state, read, write, byteenable, inwrite, pcwrite, regwrite,
               pctoadd, alusrc, signed_imm, regdst, link, memtoreg, loadimmed,
               hitoreg, lotoreg, regtojump, branch, jump, bytewrite, halfwrite,
               extend_op, div_mult_en, div_mult_signed, div_mult_op, result, zero
    );
endinterface

// File: rtl/mips_ctrl_alu.sv
// Multicycle MIPS-I control core: phase FSM, main decoder, ALU-control decode and 32-bit ALU.
// Everything except the phase register and the running flag is combinational.
module mips_ctrl_alu (
    input  logic            clk,
    input  logic            reset,
    mips_ctrl_alu_if.master bus
);
    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC1  = 3'd3,
        S_EXEC2  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_RTYPE  = 4'b0010;
    localparam logic [3:0] ALU_BEQ    = 4'b0011;
    localparam logic [3:0] ALU_BNE    = 4'b0100;
    localparam logic [3:0] ALU_BLEZ   = 4'b0101;
    localparam logic [3:0] ALU_BGTZ   = 4'b0110;
    localparam logic [3:0] ALU_REGIMM = 4'b0111;
    localparam logic [3:0] ALU_AND    = 4'b1000;
    localparam logic [3:0] ALU_OR     = 4'b1001;
    localparam logic [3:0] ALU_XOR    = 4'b1010;
    localparam logic [3:0] ALU_SLT    = 4'b1011;
    localparam logic [3:0] ALU_SLTU   = 4'b1100;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    state_t r_state;
    state_t w_state_next;
    logic   r_active;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic [4:0] w_shamt;

    assign w_op    = bus.instr[31:26];
    assign w_rt    = bus.instr[20:16];
    assign w_shamt = bus.instr[10:6];
    assign w_funct = bus.instr[5:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HALT:   w_state_next = S_FETCH;
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_EXEC1;
            S_EXEC1:  w_state_next = S_EXEC2;
            S_EXEC2:  w_state_next = S_FETCH;
            default:  w_state_next = S_HALT;
        endcase
    end

    // A zero PC halts the core even mid-stall; it outranks normal advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_HALT;
            r_active <= 1'b0;
        end else if (r_state != S_HALT && bus.pc_zero) begin
            r_state  <= S_HALT;
            r_active <= 1'b0;
        end else if (!bus.waitrequest) begin
            r_state <= w_state_next;
            if (r_state == S_HALT)
                r_active <= 1'b1;
        end
    end

    logic [3:0] w_aluop;
    logic       w_alusrc, w_signed_imm, w_regdst, w_link, w_regwr, w_memtoreg;
    logic       w_loadimmed, w_hitoreg, w_lotoreg, w_regtojump, w_branch, w_jump;
    logic       w_load, w_store, w_dm_en, w_dm_signed;
    logic [2:0] w_extend;
    logic [1:0] w_size, w_dm_op;
    logic [3:0] w_store_be;

    always_comb begin
        w_aluop = ALU_ADD;
        w_alusrc = 1'b0; w_signed_imm = 1'b0; w_regdst = 1'b0; w_link = 1'b0;
        w_regwr = 1'b0; w_memtoreg = 1'b0; w_loadimmed = 1'b0; w_hitoreg = 1'b0;
        w_lotoreg = 1'b0; w_regtojump = 1'b0; w_branch = 1'b0; w_jump = 1'b0;
        w_load = 1'b0; w_store = 1'b0; w_dm_en = 1'b0; w_dm_signed = 1'b0;
        w_extend = 3'b000; w_size = SZ_WORD; w_dm_op = 2'b00;
        case (w_op)
            6'b000000: begin
                w_aluop  = ALU_RTYPE;
                w_regdst = 1'b1;
                case (w_funct)
                    6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                    6'b100110, 6'b100111, 6'b101010, 6'b101011: w_regwr = 1'b1;
                    6'b001000: begin w_jump = 1'b1; w_regtojump = 1'b1; end
                    6'b001001: begin
                        w_jump = 1'b1; w_regtojump = 1'b1; w_link = 1'b1; w_regwr = 1'b1;
                    end
                    6'b010000: begin w_hitoreg = 1'b1; w_regwr = 1'b1; end
                    6'b010010: begin w_lotoreg = 1'b1; w_regwr = 1'b1; end
                    6'b010001: begin w_dm_en = 1'b1; w_dm_op = 2'b10; end
                    6'b010011: begin w_dm_en = 1'b1; w_dm_op = 2'b11; end
                    6'b011000: begin w_dm_en = 1'b1; w_dm_signed = 1'b1; w_dm_op = 2'b00; end
                    6'b011001: begin w_dm_en = 1'b1; w_dm_op = 2'b00; end
                    6'b011010: begin w_dm_en = 1'b1; w_dm_signed = 1'b1; w_dm_op = 2'b01; end
                    6'b011011: begin w_dm_en = 1'b1; w_dm_op = 2'b01; end
                    default: begin w_aluop = ALU_ADD; w_regdst = 1'b0; end
                endcase
            end
            // Only the four defined rt encodings are branches; rt[4] marks the linking forms.
            6'b000001: if (w_rt == 5'b00000 || w_rt == 5'b00001 ||
                           w_rt == 5'b10000 || w_rt == 5'b10001) begin
                w_aluop = ALU_REGIMM; w_branch = 1'b1; w_signed_imm = 1'b1;
                w_link = w_rt[4]; w_regwr = w_rt[4];
            end
            6'b000010: w_jump = 1'b1;
            6'b000011: begin w_jump = 1'b1; w_link = 1'b1; w_regwr = 1'b1; end
            6'b000100: begin w_aluop = ALU_BEQ;  w_branch = 1'b1; w_signed_imm = 1'b1; end
            6'b000101: begin w_aluop = ALU_BNE;  w_branch = 1'b1; w_signed_imm = 1'b1; end
            6'b000110: begin w_aluop = ALU_BLEZ; w_branch = 1'b1; w_signed_imm = 1'b1; end
            6'b000111: begin w_aluop = ALU_BGTZ; w_branch = 1'b1; w_signed_imm = 1'b1; end
            6'b001001: begin w_aluop = ALU_ADD;  w_alusrc = 1'b1; w_signed_imm = 1'b1; w_regwr = 1'b1; end
            6'b001010: begin w_aluop = ALU_SLT;  w_alusrc = 1'b1; w_signed_imm = 1'b1; w_regwr = 1'b1; end
            6'b001011: begin w_aluop = ALU_SLTU; w_alusrc = 1'b1; w_signed_imm = 1'b1; w_regwr = 1'b1; end
            6'b001100: begin w_aluop = ALU_AND;  w_alusrc = 1'b1; w_regwr = 1'b1; end
            6'b001101: begin w_aluop = ALU_OR;   w_alusrc = 1'b1; w_regwr = 1'b1; end
            6'b001110: begin w_aluop = ALU_XOR;  w_alusrc = 1'b1; w_regwr = 1'b1; end
            6'b001111: begin w_loadimmed = 1'b1; w_alusrc = 1'b1; w_regwr = 1'b1; end
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
                w_alusrc = 1'b1; w_signed_imm = 1'b1; w_regwr = 1'b1; w_load = 1'b1;
                case (w_op)
                    6'b100000: w_extend = 3'b111;
                    6'b100001: w_extend = 3'b101;
                    6'b100100: w_extend = 3'b110;
                    6'b100101: w_extend = 3'b100;
                    default:   w_memtoreg = 1'b1;
                endcase
            end
            6'b101000: begin w_alusrc = 1'b1; w_signed_imm = 1'b1; w_store = 1'b1; w_size = SZ_BYTE; end
            6'b101001: begin w_alusrc = 1'b1; w_signed_imm = 1'b1; w_store = 1'b1; w_size = SZ_HALF; end
            6'b101011: begin w_alusrc = 1'b1; w_signed_imm = 1'b1; w_store = 1'b1; w_size = SZ_WORD; end
            default: ;
        endcase
    end

    assign w_store_be = (w_size == SZ_WORD) ? 4'b1111 :
                        (w_size == SZ_HALF) ? (bus.addr_lsb[1] ? 4'b1100 : 4'b0011) :
                                              (4'b0001 << bus.addr_lsb);

    always_comb begin
        bus.active = r_active;
        bus.state  = r_state;
        bus.read = 1'b0; bus.write = 1'b0; bus.byteenable = 4'b0000;
        bus.inwrite = 1'b0; bus.pcwrite = 1'b0; bus.regwrite = 1'b0; bus.pctoadd = 1'b0;
        bus.alusrc = 1'b0; bus.signed_imm = 1'b0; bus.regdst = 1'b0; bus.link = 1'b0;
        bus.memtoreg = 1'b0; bus.loadimmed = 1'b0; bus.hitoreg = 1'b0; bus.lotoreg = 1'b0;
        bus.regtojump = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0;
        bus.bytewrite = 1'b0; bus.halfwrite = 1'b0; bus.extend_op = 3'b000;
        bus.div_mult_en = 1'b0; bus.div_mult_signed = 1'b0; bus.div_mult_op = 2'b00;
        if (r_state == S_EXEC1 || r_state == S_EXEC2) begin
            bus.alusrc = w_alusrc; bus.signed_imm = w_signed_imm; bus.regdst = w_regdst;
            bus.link = w_link; bus.memtoreg = w_memtoreg; bus.loadimmed = w_loadimmed;
            bus.hitoreg = w_hitoreg; bus.lotoreg = w_lotoreg; bus.extend_op = w_extend;
            bus.bytewrite = w_store && (w_size == SZ_BYTE);
            bus.halfwrite = w_store && (w_size != SZ_WORD);
        end
        case (r_state)
            S_FETCH: begin
                bus.read = 1'b1; bus.pctoadd = 1'b1; bus.byteenable = 4'b1111;
                bus.inwrite = !bus.waitrequest;
            end
            S_EXEC1: begin
                bus.branch = w_branch; bus.jump = w_jump; bus.regtojump = w_regtojump;
                bus.div_mult_en = w_dm_en; bus.div_mult_signed = w_dm_signed;
                bus.div_mult_op = w_dm_op;
            end
            S_EXEC2: begin
                bus.read  = w_load;
                bus.write = w_store;
                if (w_load)       bus.byteenable = 4'b1111;
                else if (w_store) bus.byteenable = w_store_be;
                bus.regwrite = w_regwr && !bus.waitrequest;
                bus.pcwrite  = !bus.waitrequest;
            end
            default: ;
        endcase
    end

    logic [31:0] w_result;
    logic        w_is_br;
    logic        w_cond;

    always_comb begin
        w_result = 32'd0;
        w_is_br  = 1'b0;
        w_cond   = 1'b0;
        case (w_aluop)
            ALU_ADD:  w_result = bus.alu_a + bus.alu_b;
            ALU_RTYPE: begin
                case (w_funct)
                    6'b000000: w_result = bus.alu_b << w_shamt;
                    6'b000010: w_result = bus.alu_b >> w_shamt;
                    6'b000011: w_result = $unsigned($signed(bus.alu_b) >>> w_shamt);
                    6'b000100: w_result = bus.alu_b << bus.alu_a[4:0];
                    6'b000110: w_result = bus.alu_b >> bus.alu_a[4:0];
                    6'b000111: w_result = $unsigned($signed(bus.alu_b) >>> bus.alu_a[4:0]);
                    6'b001000, 6'b001001: w_result = bus.alu_a;
                    6'b100010, 6'b100011: w_result = bus.alu_a - bus.alu_b;
                    6'b100100: w_result = bus.alu_a & bus.alu_b;
                    6'b100101: w_result = bus.alu_a | bus.alu_b;
                    6'b100110: w_result = bus.alu_a ^ bus.alu_b;
                    6'b100111: w_result = ~(bus.alu_a | bus.alu_b);
                    6'b101010: w_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
                    6'b101011: w_result = {31'd0, bus.alu_a < bus.alu_b};
                    default:   w_result = bus.alu_a + bus.alu_b;
                endcase
            end
            ALU_BEQ, ALU_BNE, ALU_BLEZ, ALU_BGTZ, ALU_REGIMM: begin
                w_is_br  = 1'b1;
                w_result = bus.alu_a - bus.alu_b;
                case (w_aluop)
                    ALU_BEQ:  w_cond = (bus.alu_a == bus.alu_b);
                    ALU_BNE:  w_cond = (bus.alu_a != bus.alu_b);
                    ALU_BLEZ: w_cond = bus.alu_a[31] || (bus.alu_a == 32'd0);
                    ALU_BGTZ: w_cond = !bus.alu_a[31] && (bus.alu_a != 32'd0);
                    default:  w_cond = w_rt[0] ? !bus.alu_a[31] : bus.alu_a[31];
                endcase
            end
            ALU_AND:  w_result = bus.alu_a & bus.alu_b;
            ALU_OR:   w_result = bus.alu_a | bus.alu_b;
            ALU_XOR:  w_result = bus.alu_a ^ bus.alu_b;
            ALU_SLT:  w_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            ALU_SLTU: w_result = {31'd0, bus.alu_a < bus.alu_b};
            default:  w_result = bus.alu_a + bus.alu_b;
        endcase
    end

    assign bus.result = w_result;
    assign bus.zero   = w_is_br ? w_cond : (w_result == 32'd0);
endmodule

// File: tb/tb_mips_ctrl_alu.sv
// Scoreboard bench for mips_ctrl_alu: expectations are queued when stimulus is applied
// and drained against the DUT outputs away from the rising edge.
module tb_mips_ctrl_alu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_ctrl_alu_if bus();
    mips_ctrl_alu dut (.clk(clk), .reset(reset), .bus(bus.master));

    typedef enum int {
        F_STATE, F_ACTIVE, F_READ, F_WRITE, F_BE, F_INWRITE, F_PCWRITE, F_REGWRITE,
        F_PCTOADD, F_RESULT, F_ZERO, F_BRANCH, F_JUMP, F_LINK, F_BYTEW, F_HALFW,
        F_EXT, F_MEMTOREG, F_DMEN, F_DMSIGNED, F_DMOP, F_REGTOJUMP
    } field_t;

    typedef struct {
        string       tag;
        field_t      fld;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    int seq_exp[5];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input field_t f);
        case (f)
            F_STATE:     return {29'd0, bus.state};
            F_ACTIVE:    return {31'd0, bus.active};
            F_READ:      return {31'd0, bus.read};
            F_WRITE:     return {31'd0, bus.write};
            F_BE:        return {28'd0, bus.byteenable};
            F_INWRITE:   return {31'd0, bus.inwrite};
            F_PCWRITE:   return {31'd0, bus.pcwrite};
            F_REGWRITE:  return {31'd0, bus.regwrite};
            F_PCTOADD:   return {31'd0, bus.pctoadd};
            F_RESULT:    return bus.result;
            F_ZERO:      return {31'd0, bus.zero};
            F_BRANCH:    return {31'd0, bus.branch};
            F_JUMP:      return {31'd0, bus.jump};
            F_LINK:      return {31'd0, bus.link};
            F_BYTEW:     return {31'd0, bus.bytewrite};
            F_HALFW:     return {31'd0, bus.halfwrite};
            F_EXT:       return {29'd0, bus.extend_op};
            F_MEMTOREG:  return {31'd0, bus.memtoreg};
            F_DMEN:      return {31'd0, bus.div_mult_en};
            F_DMSIGNED:  return {31'd0, bus.div_mult_signed};
            F_DMOP:      return {30'd0, bus.div_mult_op};
            F_REGTOJUMP: return {31'd0, bus.regtojump};
            default:     return 32'd0;
        endcase
    endfunction

    task automatic sb_push(input string tag, input field_t f, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag; e.fld = f; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain(input string txn);
        sb_entry_t e;
        int n;
        n = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({txn, ".", e.tag}, observe(e.fld), e.exp);
            n++;
        end
        $display("txn %-10s checks=%0d state=%0d result=%h", txn, n, bus.state, bus.result);
    endtask

    task automatic sample(input string txn);
        @(negedge clk);
        sb_drain(txn);
    endtask

    // Always takes at least one edge so repeated visits see a fresh entry into the state.
    task automatic goto_state(input logic [2:0] target);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.state !== target && n < 12);
        check_val("reach_state", {29'd0, bus.state}, {29'd0, target});
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] shamt);
        return {6'd0, 5'd0, 5'd0, 5'd0, shamt, funct};
    endfunction

    task automatic exec1_branch(input string txn, input logic [31:0] ins,
                                input logic [31:0] a, input logic [31:0] b, input logic exp_zero);
        bus.instr = ins; bus.alu_a = a; bus.alu_b = b;
        goto_state(3'd3);
        sb_push("branch", F_BRANCH, 32'd1);
        sb_push("zero", F_ZERO, {31'd0, exp_zero});
        sample(txn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        seq_exp = '{1, 2, 3, 4, 1};
        reset = 1'b0;
        bus.waitrequest = 1'b0; bus.pc_zero = 1'b0; bus.instr = 32'd0;
        bus.addr_lsb = 2'd0; bus.alu_a = 32'd0; bus.alu_b = 32'd0;
        repeat (2) @(posedge clk);
        sb_push("state", F_STATE, 32'd0);  sb_push("active", F_ACTIVE, 32'd0);
        sb_push("read", F_READ, 32'd0);    sb_push("be", F_BE, 32'd0);
        sb_push("pcwrite", F_PCWRITE, 32'd0); sb_push("inwrite", F_INWRITE, 32'd0);
        sample("reset");
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            sb_push("state", F_STATE, seq_exp[i]);
            sb_push("active", F_ACTIVE, 32'd1);
            if (i == 0) begin
                sb_push("read", F_READ, 32'd1); sb_push("be", F_BE, 32'hF);
                sb_push("inwrite", F_INWRITE, 32'd1); sb_push("pctoadd", F_PCTOADD, 32'd1);
            end
            if (i == 1) begin
                sb_push("read", F_READ, 32'd0); sb_push("be", F_BE, 32'd0);
                sb_push("inwrite", F_INWRITE, 32'd0);
            end
            if (i == 3) begin
                sb_push("pcwrite", F_PCWRITE, 32'd1); sb_push("regwrite", F_REGWRITE, 32'd1);
            end
            sample("sequence");
        end

        bus.instr = rtype(6'b100001, 5'd0); bus.alu_a = 32'hFFFF_FFFF; bus.alu_b = 32'd1;
        sb_push("result", F_RESULT, 32'd0); sb_push("zero", F_ZERO, 32'd1);
        sample("addu_wrap");
        bus.instr = rtype(6'b101010, 5'd0);
        sb_push("result", F_RESULT, 32'd1); sb_push("zero", F_ZERO, 32'd0);
        sample("slt");
        bus.instr = rtype(6'b101011, 5'd0);
        sb_push("result", F_RESULT, 32'd0);
        sample("sltu");
        bus.instr = rtype(6'b000011, 5'd4); bus.alu_a = 32'd0; bus.alu_b = 32'h8000_0000;
        sb_push("result", F_RESULT, 32'hF800_0000);
        sample("sra");

        for (int k = 0; k < 8; k++) begin
            logic [31:0] ra, rb, ex;
            logic [5:0]  fn;
            ra = $urandom; rb = $urandom;
            case (k)
                0: begin fn = 6'b100001; ex = ra + rb; end
                1: begin fn = 6'b100011; ex = ra - rb; end
                2: begin fn = 6'b100100; ex = ra & rb; end
                3: begin fn = 6'b100101; ex = ra | rb; end
                4: begin fn = 6'b100110; ex = ra ^ rb; end
                5: begin fn = 6'b100111; ex = ~(ra | rb); end
                6: begin fn = 6'b000100; ex = rb << ra[4:0]; end
                default: begin fn = 6'b000110; ex = rb >> ra[4:0]; end
            endcase
            bus.instr = rtype(fn, 5'd0); bus.alu_a = ra; bus.alu_b = rb;
            sb_push("result", F_RESULT, ex);
            sb_push("zero", F_ZERO, {31'd0, ex == 32'd0});
            sample("alu_rand");
        end

        bus.instr = {6'b101000, 26'd0}; bus.addr_lsb = 2'd2;
        goto_state(3'd4);
        sb_push("write", F_WRITE, 32'd1); sb_push("read", F_READ, 32'd0);
        sb_push("be", F_BE, 32'b0100); sb_push("bytew", F_BYTEW, 32'd1);
        sb_push("halfw", F_HALFW, 32'd1); sb_push("pcwrite", F_PCWRITE, 32'd1);
        sb_push("regwrite", F_REGWRITE, 32'd0); sb_push("pctoadd", F_PCTOADD, 32'd0);
        sample("sb_lsb2");
        bus.addr_lsb = 2'd3;
        goto_state(3'd4);
        sb_push("be", F_BE, 32'b1000);
        sample("sb_lsb3");

        bus.instr = {6'b101001, 26'd0}; bus.addr_lsb = 2'd2;
        goto_state(3'd4);
        sb_push("be", F_BE, 32'b1100); sb_push("halfw", F_HALFW, 32'd1);
        sb_push("bytew", F_BYTEW, 32'd0); sb_push("write", F_WRITE, 32'd1);
        sample("sh_lsb2");
        bus.addr_lsb = 2'd0;
        goto_state(3'd4);
        sb_push("be", F_BE, 32'b0011);
        sample("sh_lsb0");

        bus.instr = {6'b100000, 26'd0}; bus.addr_lsb = 2'd2;
        goto_state(3'd4);
        sb_push("read", F_READ, 32'd1); sb_push("be", F_BE, 32'hF);
        sb_push("ext", F_EXT, 32'b111); sb_push("write", F_WRITE, 32'd0);
        sb_push("regwrite", F_REGWRITE, 32'd1); sb_push("memtoreg", F_MEMTOREG, 32'd0);
        sample("lb");
        bus.instr = {6'b100011, 26'd0};
        goto_state(3'd4);
        sb_push("memtoreg", F_MEMTOREG, 32'd1); sb_push("ext", F_EXT, 32'd0);
        sample("lw");
        bus.instr = {6'b100010, 26'd0};
        goto_state(3'd4);
        sb_push("read", F_READ, 32'd0); sb_push("regwrite", F_REGWRITE, 32'd0);
        sb_push("pcwrite", F_PCWRITE, 32'd1); sb_push("be", F_BE, 32'd0);
        sample("lwl_nop");

        exec1_branch("bgezal", {6'b000001, 5'd0, 5'b10001, 16'd4}, 32'd0, 32'd0, 1'b1);
        goto_state(3'd4);
        sb_push("regwrite", F_REGWRITE, 32'd1); sb_push("link", F_LINK, 32'd1);
        sample("bgezal_wb");
        exec1_branch("bltz_zero", {6'b000001, 5'd0, 5'b00000, 16'd4}, 32'd0, 32'd0, 1'b0);
        exec1_branch("bltz_neg", {6'b000001, 5'd0, 5'b00000, 16'd4}, 32'h8000_0000, 32'd0, 1'b1);
        exec1_branch("blez_zero", {6'b000110, 26'd4}, 32'd0, 32'd0, 1'b1);
        exec1_branch("bgtz_zero", {6'b000111, 26'd4}, 32'd0, 32'd0, 1'b0);
        exec1_branch("bne_eq", {6'b000101, 26'd4}, 32'd5, 32'd5, 1'b0);
        exec1_branch("beq_eq", {6'b000100, 26'd4}, 32'd5, 32'd5, 1'b1);

        bus.instr = rtype(6'b011000, 5'd0);
        goto_state(3'd3);
        sb_push("dmen", F_DMEN, 32'd1); sb_push("dmsigned", F_DMSIGNED, 32'd1);
        sb_push("dmop", F_DMOP, 32'd0);
        sample("mult");
        bus.instr = rtype(6'b011011, 5'd0);
        goto_state(3'd3);
        sb_push("dmen", F_DMEN, 32'd1); sb_push("dmsigned", F_DMSIGNED, 32'd0);
        sb_push("dmop", F_DMOP, 32'd1);
        sample("divu");
        bus.instr = rtype(6'b001000, 5'd0); bus.alu_a = 32'h1234_5678;
        goto_state(3'd3);
        sb_push("jump", F_JUMP, 32'd1); sb_push("regtojump", F_REGTOJUMP, 32'd1);
        sb_push("result", F_RESULT, 32'h1234_5678);
        sample("jr");

        bus.instr = 32'd0;
        goto_state(3'd1);
        bus.waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_push("state", F_STATE, 32'd1); sb_push("read", F_READ, 32'd1);
            sb_push("inwrite", F_INWRITE, 32'd0); sb_push("be", F_BE, 32'hF);
            sample("fetch_stall");
            @(posedge clk); #1;
        end
        bus.waitrequest = 1'b0;
        sb_push("state", F_STATE, 32'd1); sb_push("inwrite", F_INWRITE, 32'd1);
        sample("fetch_go");
        @(posedge clk); #1;
        sb_push("state", F_STATE, 32'd2);
        sample("decode");

        goto_state(3'd4);
        bus.waitrequest = 1'b1;
        sb_push("pcwrite", F_PCWRITE, 32'd0); sb_push("regwrite", F_REGWRITE, 32'd0);
        sample("exec2_stall");
        @(posedge clk); #1;
        bus.waitrequest = 1'b0;
        sb_push("state", F_STATE, 32'd4); sb_push("pcwrite", F_PCWRITE, 32'd1);
        sample("exec2_go");

        goto_state(3'd3);
        bus.pc_zero = 1'b1;
        @(posedge clk); #1;
        sb_push("state", F_STATE, 32'd0); sb_push("active", F_ACTIVE, 32'd0);
        sb_push("read", F_READ, 32'd0); sb_push("write", F_WRITE, 32'd0);
        sb_push("be", F_BE, 32'd0); sb_push("pcwrite", F_PCWRITE, 32'd0);
        sb_push("inwrite", F_INWRITE, 32'd0);
        sample("pc_zero");
        bus.pc_zero = 1'b0;
        @(posedge clk); #1;
        sb_push("state", F_STATE, 32'd1); sb_push("active", F_ACTIVE, 32'd1);
        sample("restart");

        bus.instr = {6'b101011, 26'd0};
        goto_state(3'd4);
        sb_push("write", F_WRITE, 32'd1); sb_push("be", F_BE, 32'hF);
        sample("sw");
        reset = 1'b0;
        #1;
        sb_push("state", F_STATE, 32'd0); sb_push("active", F_ACTIVE, 32'd0);
        sb_push("write", F_WRITE, 32'd0); sb_push("pcwrite", F_PCWRITE, 32'd0);
        sb_drain("async_rst");
        reset = 1'b1;
        @(posedge clk); #1;
        sb_push("state", F_STATE, 32'd1);
        sample("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/mips_ctrl_alu.md
# mips_ctrl_alu

Sequencing, decode and arithmetic core of the multicycle MIPS-I Avalon CPU. Combines the instruction-phase state machine, main instruction decoder, ALU-control decoder and 32-bit ALU. Sits between the bus/PC/register-file datapath and the memory master: it drives every mux select, write enable and bus strobe, and computes ALU results and branch conditions.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- waitrequest  in  1  Avalon stall; state and all enables frozen while high
- pc_zero  in  1  PC equals 0; halt request
- instr  in  32  current instruction (datapath supplies readdata in DECODE, latched copy otherwise)
- addr_lsb  in  2  bits [1:0] of computed data address
- alu_a  in  32  rs operand
- alu_b  in  32  rt or immediate operand (after ALUSrc mux)
- active  out  1  CPU running
- state  out  3  0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2
- read, write  out  1  Avalon strobes
- byteenable  out  4  Avalon byte lanes
- inwrite, pcwrite, regwrite  out  1  instruction-register, PC and register-file write enables
- pctoadd, alusrc, signed_imm, regdst, link, memtoreg, loadimmed, hitoreg, lotoreg, regtojump  out  1  datapath selects
- branch, jump  out  1  branch-candidate and unconditional-jump flags
- bytewrite, halfwrite  out  1  store-data shift selects
- extend_op  out  3  load extension: 000 none, 100 LHU, 101 LH, 110 LBU, 111 LB
- div_mult_en, div_mult_signed  out  1  HI/LO unit enable and signedness
- div_mult_op  out  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- result  out  32  ALU result
- zero  out  1  branch condition true, or result==0 for non-branch ops

## Operation
- FSM: HALT->FETCH (sets active=1)->DECODE->EXEC1->EXEC2->FETCH. Advances only when waitrequest=0. In any non-HALT state, pc_zero=1 forces state=HALT and active=0 at the next edge; this takes priority over advancing.
- HALT: every control output 0, byteenable 0000.
- FETCH: read=1, pctoadd=1, byteenable=1111, inwrite=!waitrequest.
- DECODE: no strobes or enables.
- EXEC1: branch/jump/regtojump asserted for control-flow instructions; div_mult_en=1 for MULT(U)/DIV(U)/MTHI/MTLO (signed for MULT, DIV).
- EXEC2: loads assert read, stores assert write (pctoadd=0); regwrite=!waitrequest for every register-writing instruction; pcwrite=!waitrequest for every instruction.
- Stores: SW byteenable 1111; SH 0011 or 1100 by addr_lsb[1], halfwrite=1; SB 0001<<addr_lsb, bytewrite=1, halfwrite=1. Loads always read with 1111; LW memtoreg=1, others via extend_op.
- Writes: R-type regdst=1; I-type regdst=0; JAL/BLTZAL/BGEZAL link=1, regdst=0 (rt forced to $31 outside), regwrite unconditional; JALR link=1, regdst=1; LUI loadimmed=1; MFHI hitoreg, MFLO lotoreg. signed_imm=1 for ADDIU, SLTI, SLTIU, loads, stores, branches; 0 for ANDI/ORI/XORI.
- Unsupported opcodes/functs (including LWL/LWR, SYSCALL): execute as NOP, only pcwrite.
- ALUOp (internal, 4 bits): 0000 add, 0010 R-type funct, 0011 BEQ, 0100 BNE, 0101 BLEZ, 0110 BGTZ, 0111 REGIMM (rt selects BLTZ/BGEZ/AL variants), 1000 AND, 1001 OR, 1010 XOR, 1011 SLT, 1100 SLTU.
- ALU ops: ADD/ADDU and SUB/SUBU wrap modulo 2^32 with no overflow trap; AND, OR, XOR, NOR; SLT signed, SLTU unsigned (result 0 or 1); SLL/SRL/SRA shift alu_b by instr[10:6]; SLLV/SRLV/SRAV shift alu_b by alu_a[4:0]; JR/JALR pass alu_a.
- Branch ops set zero: EQ a==b, NE a!=b, LEZ a<=0, GTZ a>0, LTZ a<0, GEZ a>=0 (signed). Branch taken = branch & zero.

## Timing
- Asynchronous reset: state=HALT and active=0 immediately; all outputs then follow HALT decode.
- Decoder, ALU-control decoder and ALU are purely combinational from state, instr, addr_lsb and operands; same-cycle outputs.
- One instruction every 4 non-stalled cycles (FETCH..EXEC2); waitrequest=1 stretches the current state indefinitely while strobes hold steady.
- Reset asserted mid-instruction abandons it; no write enable is asserted in the reset cycle.

## Test plan
- Reset low, then high with waitrequest=0 -> state 0,1,2,3,4,1 on successive edges; active=1 from the first edge after reset.
- ADDU instr, a=0xFFFFFFFF, b=1 -> result=0, zero=1; SLT a=0xFFFFFFFF, b=1 -> result=1; SLTU -> 0; SRA b=0x80000000, shamt=4 -> 0xF8000000.
- SB at addr_lsb=2 in EXEC2 -> write=1, byteenable=0100, bytewrite=1; SH at addr_lsb=2 -> 1100; LB -> read=1, byteenable=1111, extend_op=111.
- BGEZAL with a=0 in EXEC1 -> branch=1, zero=1; in EXEC2 regwrite=1, link=1.
- waitrequest=1 during FETCH for 3 cycles -> state stays 1, read=1, inwrite=0; advances after drop.
- pc_zero=1 while in EXEC1 -> next edge state=0, active=0, all strobes 0.
